restoring_divider4: RTL and testbench
=====================================

# restoring_divider4

Sequential 4-bit unsigned restoring divider. It computes quotient and remainder of `dividend / divisor` over four iterations. Each iteration issues one trial subtraction through the team's 4-bit ripple add/subtract adder in subtract mode (b inverted, carry-in = 1). The block sits directly downstream of that adder in the arithmetic lab datapath, consuming its sum and carry-out every cycle, and presents a start/done handshake to the operand sequencer.

## Interface
- `WIDTH`, default 4. Operand width. Fixed at 4; no other value is supported.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request a division. Sampled only when not `busy`.
- `dividend` in 4: unsigned dividend. Sampled on the accepting edge.
- `divisor` in 4: unsigned divisor. Sampled on the accepting edge.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse marking the cycle in which results first become valid.
- `quotient` out 4: registered result, held until the next `done`.
- `remainder` out 4: registered result, held until the next `done`.
- `div_by_zero` out 1: registered flag, valid with `done`, held until the next `done`.

## Operation
- States:
  - IDLE: reset state.
  - RUN: iteration count 0..3.
  - DONE: one cycle.
- IDLE or DONE with `start`=1, `divisor`≠0:
  - Latch Q←`dividend`, D←`divisor`, R←5'b0, count←0; go to RUN.
- IDLE or DONE with `start`=1, `divisor`=0:
  - Go to DONE directly.
  - `quotient`←4'hF, `remainder`←`dividend`, `div_by_zero`←1.
- RUN iteration, one per cycle:
  - Shift {R,Q} left by 1; R is 5 bits.
  - Trial T = R − {0,D}. The low 4 bits come from the adder in subtract mode (a=R[3:0], b=D, cin=1).
  - No-borrow condition: `R[4] | cout`.
  - If no borrow: R←{0,T[3:0]}, Q[0]←1. Otherwise R is unchanged and Q[0]←0.
  - count increments; after the count=3 iteration go to DONE.
- Entering DONE from RUN:
  - `quotient`←Q, `remainder`←R[3:0], `div_by_zero`←0.
- DONE with no `start`: go to IDLE.
- `start` while in RUN is ignored. The latched operands are not disturbed by input changes during RUN.
- Invariant: `remainder` < `divisor` and `quotient`·`divisor`+`remainder` = `dividend` for every nonzero divisor, across all 256 operand pairs.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
  - Internal R, Q, D and count = 0.
- Normal latency, with `start` sampled at the end of cycle 0:
  - Cycles 1–4: RUN with `busy`=1.
  - Cycle 5: DONE with `done`=1, `busy`=0, results valid.
- Divide-by-zero latency: `done`=1 in cycle 1; `busy` stays 0 throughout.
- `done` is high for exactly one cycle per accepted `start`.
- Back-to-back: `start` asserted in the DONE cycle is accepted. The new RUN starts the next cycle and the old results stay held until the new `done`.
- `busy` and `done` are never high together.
- `rst` asserted in any state, including mid-RUN:
  - Next edge returns to IDLE with all outputs at their reset values.
  - An aborted division produces no `done`.
- `rst` has priority over `start` on the same edge.

## Test plan
- 13 / 4, `start` in cycle 0 -> `done` in cycle 5 only; `quotient`=3, `remainder`=1, `div_by_zero`=0; `busy` high in cycles 1–4.
- 15 / 1 -> `quotient`=15, `remainder`=0. Then 3 / 7 -> `quotient`=0, `remainder`=3. Then 15 / 15 -> `quotient`=1, `remainder`=0.
- 9 / 0 -> `done` in cycle 1, `quotient`=4'hF, `remainder`=9, `div_by_zero`=1, `busy` never high. A following 9 / 2 clears `div_by_zero` and returns `quotient`=4, `remainder`=1.
- Start 14 / 3. In cycle 2, drive `start`=1 with operands 5 / 5 -> ignored; result is `quotient`=4, `remainder`=2 in cycle 5. A `start` of 5 / 5 held in cycle 5 is accepted -> `quotient`=1, `remainder`=0 in cycle 10.
- Start 12 / 5, assert `rst` in cycle 3 -> all outputs 0 from cycle 4; no `done` pulse ever. A subsequent 12 / 5 yields `quotient`=2, `remainder`=2.
- Exhaustive sweep of all 256 dividend/divisor pairs, back-to-back -> every result matches the integer reference model; exactly one `done` per `start`.

Source files
------------

// File: rtl/restoring_divider4_if.sv
// restoring_divider4_if: start/done handshake and operand/result bus of the 4-bit restoring divider
interface restoring_divider4_if #(parameter int WIDTH = 4);
   logic start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic busy;
   logic done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic div_by_zero;
   modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
   modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/restoring_divider4.sv
// restoring_divider4: sequential 4-bit unsigned restoring divider, one trial subtraction per cycle
module restoring_divider4 #(parameter int WIDTH = 4) (
   input logic clk,
   input logic rst,
   restoring_divider4_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state;
   logic [WIDTH:0] r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;
   logic [1:0] cnt;
   logic [WIDTH:0] rs;
   logic [WIDTH:0] t;
   logic nb;
   logic [WIDTH:0] rn;
   logic [WIDTH-1:0] qn;
   // adder in subtract mode: a + ~b + 1, bit WIDTH of t is its carry-out
   always_comb begin
      rs = {r[WIDTH-1:0], q[WIDTH-1]};
      t = {1'b0, rs[WIDTH-1:0]} + {1'b0, ~d} + {{WIDTH{1'b0}}, 1'b1};
      nb = rs[WIDTH] | t[WIDTH];
      rn = nb ? {1'b0, t[WIDTH-1:0]} : rs;
      qn = {q[WIDTH-2:0], nb};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         r <= '0;
         q <= '0;
         d <= '0;
         cnt <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.quotient <= '0;
         bus.remainder <= '0;
         bus.div_by_zero <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (state == RUN) begin
            r <= rn;
            q <= qn;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
               state <= DONE;
               bus.busy <= 1'b0;
               bus.done <= 1'b1;
               bus.quotient <= qn;
               bus.remainder <= rn[WIDTH-1:0];
               bus.div_by_zero <= 1'b0;
            end
         end else if (bus.start && bus.divisor == '0) begin
            state <= DONE;
            bus.done <= 1'b1;
            bus.quotient <= {WIDTH{1'b1}};
            bus.remainder <= bus.dividend;
            bus.div_by_zero <= 1'b1;
         end else if (bus.start) begin
            state <= RUN;
            q <= bus.dividend;
            d <= bus.divisor;
            r <= '0;
            cnt <= '0;
            bus.busy <= 1'b1;
         end else begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_restoring_divider4.sv
// tb_restoring_divider4: directed vector table, handshake corner sequences and a full operand sweep
module tb_restoring_divider4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   restoring_divider4_if itf ();
   restoring_divider4 dut (.clk(clk), .rst(rst), .bus(itf));
   always #5 clk = ~clk;
   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] q;
      logic [3:0] r;
      logic z;
   } vec_t;
   vec_t vt [7];
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic check_outs(input string name, input int q, input int r, input int z);
      check({name, "_quotient"}, int'(itf.quotient), q);
      check({name, "_remainder"}, int'(itf.remainder), r);
      check({name, "_dbz"}, int'(itf.div_by_zero), z);
   endtask
   // start in the current cycle, return the cycle (relative to start) in which done appears, 0 on timeout
   task automatic run(input logic [3:0] a, input logic [3:0] b, output int lat);
      itf.start = 1'b1;
      itf.dividend = a;
      itf.divisor = b;
      tick;
      itf.start = 1'b0;
      lat = 0;
      for (int c = 1; c <= 10; c++) begin
         check("busy_done_excl", int'(itf.busy & itf.done), 0);
         if (itf.done) begin
            lat = c;
            break;
         end
         check("busy_in_run", int'(itf.busy), int'(b != 0 && c <= 4));
         tick;
      end
   endtask
   initial begin
      int lat;
      int dones;
      int found;
      vt[0] = '{4'd13, 4'd4, 4'd3, 4'd1, 1'b0};
      vt[1] = '{4'd15, 4'd1, 4'd15, 4'd0, 1'b0};
      vt[2] = '{4'd3, 4'd7, 4'd0, 4'd3, 1'b0};
      vt[3] = '{4'd15, 4'd15, 4'd1, 4'd0, 1'b0};
      vt[4] = '{4'd9, 4'd0, 4'd15, 4'd9, 1'b1};
      vt[5] = '{4'd9, 4'd2, 4'd4, 4'd1, 1'b0};
      vt[6] = '{4'd6, 4'd3, 4'd2, 4'd0, 1'b0};
      itf.start = 1'b0;
      itf.dividend = 4'd0;
      itf.divisor = 4'd0;
      tick;
      tick;
      rst = 1'b0;
      check("reset_busy", int'(itf.busy), 0);
      check("reset_done", int'(itf.done), 0);
      check_outs("reset", 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         run(vt[i].a, vt[i].b, lat);
         check("latency", lat, vt[i].b == 4'd0 ? 1 : 5);
         check("busy_at_done", int'(itf.busy), 0);
         check_outs("vec", int'(vt[i].q), int'(vt[i].r), int'(vt[i].z));
         tick;
         check("done_one_cycle", int'(itf.done), 0);
         check_outs("vec_held", int'(vt[i].q), int'(vt[i].r), int'(vt[i].z));
      end
      // start during RUN is ignored; start in DONE cycle is accepted
      itf.start = 1'b1;
      itf.dividend = 4'd14;
      itf.divisor = 4'd3;
      tick;
      itf.start = 1'b0;
      tick;
      itf.start = 1'b1;
      itf.dividend = 4'd5;
      itf.divisor = 4'd5;
      tick;
      itf.start = 1'b0;
      itf.dividend = 4'd0;
      itf.divisor = 4'd0;
      tick;
      check("ign_no_done_c4", int'(itf.done), 0);
      tick;
      check("ign_done_c5", int'(itf.done), 1);
      check_outs("ign", 4, 2, 0);
      itf.start = 1'b1;
      itf.dividend = 4'd5;
      itf.divisor = 4'd5;
      tick;
      itf.start = 1'b0;
      check("b2b_busy_c6", int'(itf.busy), 1);
      check_outs("b2b_held", 4, 2, 0);
      for (int c = 7; c <= 9; c++) begin
         tick;
         check("b2b_no_done", int'(itf.done), 0);
      end
      tick;
      check("b2b_done_c10", int'(itf.done), 1);
      check_outs("b2b", 1, 0, 0);
      tick;
      // reset mid-RUN aborts without a done pulse
      itf.start = 1'b1;
      itf.dividend = 4'd12;
      itf.divisor = 4'd5;
      tick;
      itf.start = 1'b0;
      tick;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("abort_busy", int'(itf.busy), 0);
      check("abort_done", int'(itf.done), 0);
      check_outs("abort", 0, 0, 0);
      found = 0;
      for (int c = 0; c < 8; c++) begin
         if (itf.done) found++;
         tick;
      end
      check("abort_no_done", found, 0);
      run(4'd12, 4'd5, lat);
      check("after_abort_lat", lat, 5);
      check_outs("after_abort", 2, 2, 0);
      tick;
      // exhaustive back-to-back sweep: each start issued in the previous done cycle
      dones = 0;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            itf.start = 1'b1;
            itf.dividend = 4'(a);
            itf.divisor = 4'(b);
            tick;
            itf.start = 1'b0;
            found = 0;
            for (int c = 1; c <= 10; c++) begin
               if (itf.done) begin
                  dones++;
                  found = 1;
                  break;
               end
               tick;
            end
            check("sweep_found_done", found, 1);
            if (b == 0) check_outs("sweep_dz", 15, a, 1);
            else check_outs("sweep", a / b, a % b, 0);
         end
      end
      check("sweep_done_count", dones, 256);
      tick;
      check("sweep_final_idle", int'(itf.done), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
